// File: rtl/fp_sgnj_arbiter_if.sv
// Request/response bundle for the shared FP32 sign-injection arbiter.
// master = requester/consumer side, slave = arbiter side.
interface fp_sgnj_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [32*NREQ-1:0] req_rs1;
   logic [32*NREQ-1:0] req_rs2;
   logic [2*NREQ-1:0]  req_op;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_data;
   logic [IDW-1:0]    resp_id;
   logic              resp_err;

   modport master (
      output req_valid, req_rs1, req_rs2, req_op, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_id, resp_err
   );

   modport slave (
      input  req_valid, req_rs1, req_rs2, req_op, resp_ready,
      output req_ready, resp_valid, resp_data, resp_id, resp_err
   );
endinterface

// File: rtl/fp_sgnj_arbiter.sv
// Round-robin arbiter sharing one registered FP32 FSGNJ/FSGNJN/FSGNJX unit.
// Optional FSGNJ_ARB_PIPE_EN: retire and accept in the same cycle (1 op/cycle).
module fp_sgnj_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   fp_sgnj_arbiter_if.slave bus,
   output logic             busy
);

   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

   state_t          r_state;
   logic [IDW-1:0]  r_ptr;
   logic            r_valid;
   logic [31:0]     r_data;
   logic [IDW-1:0]  r_id;
   logic            r_err;

   logic            w_grant_en;
   logic            w_found;
   logic            w_accept;
   logic [IDW-1:0]  w_gidx;
   logic [NREQ-1:0] w_ready;
   logic [31:0]     w_a;
   logic [31:0]     w_b;
   logic [1:0]      w_op;
   logic [32:0]     w_res;

   // Returns {err, data}; illegal op yields zero data with err set.
   function automatic logic [32:0] sgnj_calc(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [1:0]  op);
      case (op)
         2'b00:   return {1'b0, b[31], a[30:0]};
         2'b01:   return {1'b0, ~b[31], a[30:0]};
         2'b10:   return {1'b0, a[31] ^ b[31], a[30:0]};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

`ifdef FSGNJ_ARB_PIPE_EN
   assign w_grant_en = EN & ((r_state == IDLE) | bus.resp_ready);
`else
   assign w_grant_en = EN & (r_state == IDLE);
`endif

   // Scan starts just after the last winner so every requester gets a turn.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(r_ptr) + k) % NREQ;
         if (!w_found && bus.req_valid[idx]) begin
            w_found = 1'b1;
            w_gidx  = IDW'(idx);
         end
      end
   end

   assign w_accept = w_grant_en & w_found;
   assign w_ready  = w_accept ? ({{(NREQ-1){1'b0}}, 1'b1} << w_gidx) : '0;

   assign w_a   = bus.req_rs1[32*w_gidx +: 32];
   assign w_b   = bus.req_rs2[32*w_gidx +: 32];
   assign w_op  = bus.req_op[2*w_gidx +: 2];
   assign w_res = sgnj_calc(w_a, w_b, w_op);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_ptr   <= IDW'(NREQ - 1);
         r_valid <= 1'b0;
         r_data  <= '0;
         r_id    <= '0;
         r_err   <= 1'b0;
      end else begin
         if (r_state == RESP && bus.resp_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
         end
         // A same-cycle accept (pipelined build) overrides the retire above.
         if (w_accept) begin
            r_state <= RESP;
            r_valid <= 1'b1;
            r_data  <= w_res[31:0];
            r_err   <= w_res[32];
            r_id    <= w_gidx;
            r_ptr   <= w_gidx;
         end
      end
   end

   assign bus.req_ready  = w_ready;
   assign bus.resp_valid = r_valid;
   assign bus.resp_data  = r_data;
   assign bus.resp_id    = r_id;
   assign bus.resp_err   = r_err;
   assign busy           = (r_state == RESP);

endmodule
